pingpong_clear_buffer: RTL and testbench

Parametrised double-buffered occupancy/pixel store for the boids renderer. One buffer is "active": it takes simulation writes and serves reads. The other buffer is swept to CLEAR_VALUE in the background, one address per cycle. A swap is requested by the frame controller and is honoured only when the background clear has finished, so a freshly swapped-in buffer is always fully cleared.

---
 rtl/pingpong_clear_buffer_pkg.sv | 12 +
 rtl/pingpong_clear_buffer_if.sv | 28 ++
 rtl/buffer_clear_sweeper.sv | 63 ++++++
 rtl/single_port_ram.sv | 21 ++
 rtl/pingpong_clear_buffer.sv | 105 ++++++++++
 tb/tb_pingpong_clear_buffer.sv | 261 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/pingpong_clear_buffer_pkg.sv
// Shared types for the ping-pong clear buffer: clear FSM encoding and buffer indices.
package pingpong_clear_buffer_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    DONE  = 1'b1
  } clear_state_e;

  localparam logic BUF0 = 1'b0;
  localparam logic BUF1 = 1'b1;

endpackage

// File: rtl/pingpong_clear_buffer_if.sv
// Frame-control and pixel read/write bus of the ping-pong clear buffer.
interface pingpong_clear_buffer_if #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  swap_req;
  logic                  swap_ack;
  logic                  clear_done;
  logic                  active_sel;
  logic [CNT_WIDTH-1:0]  swap_count;
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;

  modport master (
    output swap_req, we, write_addr, write_data, read_addr,
    input  swap_ack, clear_done, active_sel, swap_count, read_data, read_valid
  );

  modport slave (
    input  swap_req, we, write_addr, write_data, read_addr,
    output swap_ack, clear_done, active_sel, swap_count, read_data, read_valid
  );
endinterface

// File: rtl/buffer_clear_sweeper.sv
// Background clear sweep of the inactive buffer, plus swap gating and pending-request capture.
module buffer_clear_sweeper
  import pingpong_clear_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  swap_req,
  output logic                  swap_fire,
  output logic                  clear_done,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  clear_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      addr_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    swap_fire = 1'b0;
    unique case (state_q)
      CLEAR: begin
        // Requests during a sweep collapse into one deferred swap.
        if (swap_req) pending_d = 1'b1;
        if (addr_q == LastAddr) begin
          state_d = DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DONE: begin
        if (swap_req || pending_q) begin
          swap_fire = 1'b1;
          state_d   = CLEAR;
          addr_d    = '0;
          pending_d = 1'b0;
        end
      end
    endcase
  end

  assign clear_done = (state_q == DONE);
  assign clear_we   = (state_q == CLEAR);
  assign clear_addr = addr_q;
endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM with synchronous write and 1-cycle registered read (read-before-write).
module single_port_ram #(
  parameter int unsigned DATA_WIDTH    = 1,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DEPTH         = 1024
) (
  input  logic                     clk,
  input  logic                     wEn,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  output logic [DATA_WIDTH-1:0]    dataOut
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wEn) begin
      mem[addr] <= dataIn;
    end
    dataOut <= mem[addr];
  end
endmodule

// File: rtl/pingpong_clear_buffer.sv
// Double-buffered pixel store: one buffer serves the renderer while the other is swept clear.
module pingpong_clear_buffer
  import pingpong_clear_buffer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 1,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           DEPTH       = 1024,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int unsigned           CNT_WIDTH   = 16
) (
  input logic                    clk,
  input logic                    reset,
  pingpong_clear_buffer_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  logic                  swap_fire, clear_done, clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  active_sel_q, swap_ack_q, read_valid_q, rd_buf_q, rd_oob_q;
  logic [CNT_WIDTH-1:0]  swap_count_q;
  logic [DATA_WIDTH-1:0] read_hold_q, read_data;
  logic                  wr_in_range, rd_oob;
  logic [DATA_WIDTH-1:0] ram_rdata [2];

  buffer_clear_sweeper #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_sweeper (
    .clk        (clk),
    .reset      (reset),
    .swap_req   (bus.swap_req),
    .swap_fire  (swap_fire),
    .clear_done (clear_done),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign wr_in_range = (bus.write_addr <= LastAddr);
  assign rd_oob      = (bus.read_addr > LastAddr);

  // The active buffer sees only user traffic, the inactive one only the sweep.
  for (genvar b = 0; b < 2; b++) begin : g_buf
    logic                  is_active, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign is_active = (active_sel_q == 1'(b));
    assign ram_we    = is_active ? (bus.we && wr_in_range) : clear_we;
    assign ram_addr  = is_active ? (bus.we ? bus.write_addr : bus.read_addr) : clear_addr;
    assign ram_wdata = is_active ? bus.write_data : CLEAR_VALUE;

    single_port_ram #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDR_WIDTH),
      .DEPTH         (DEPTH)
    ) u_ram (
      .clk     (clk),
      .wEn     (ram_we),
      .addr    (ram_addr),
      .dataIn  (ram_wdata),
      .dataOut (ram_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_sel_q <= BUF0;
      swap_ack_q   <= 1'b0;
      swap_count_q <= '0;
      read_valid_q <= 1'b0;
      rd_buf_q     <= BUF0;
      rd_oob_q     <= 1'b0;
      read_hold_q  <= '0;
    end else begin
      swap_ack_q <= swap_fire;
      if (swap_fire) begin
        active_sel_q <= ~active_sel_q;
        swap_count_q <= swap_count_q + 1'b1;
      end
      read_valid_q <= ~bus.we;
      // Remember which buffer the read went to, so a swap-cycle read returns old data.
      rd_buf_q     <= active_sel_q;
      rd_oob_q     <= rd_oob;
      read_hold_q  <= read_data;
    end
  end

  always_comb begin
    read_data = read_hold_q;
    if (read_valid_q) begin
      if (rd_oob_q) begin
        read_data = CLEAR_VALUE;
      end else begin
        read_data = (rd_buf_q == BUF0) ? ram_rdata[0] : ram_rdata[1];
      end
    end
  end

  assign bus.swap_ack   = swap_ack_q;
  assign bus.clear_done = clear_done;
  assign bus.active_sel = active_sel_q;
  assign bus.swap_count = swap_count_q;
  assign bus.read_data  = read_data;
  assign bus.read_valid = read_valid_q;
endmodule

// File: tb/tb_pingpong_clear_buffer.sv
// Self-checking bench for pingpong_clear_buffer: scoreboarded reads plus per-scenario checks.
module tb_pingpong_clear_buffer;
  localparam int unsigned    DW = 4;
  localparam int unsigned    AW = 11;
  localparam int unsigned    D  = 1000;
  localparam int unsigned    CW = 2;
  localparam logic [DW-1:0]  CV = 4'h6;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    bit            chk;
  } sb_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  sb_t sb[$];
  sb_t mon_e;

  // Reference model of the active buffer and the clear/swap timing.
  logic [DW-1:0] m_mem [D];
  bit            m_known [D];
  logic [DW-1:0] m_last;
  bit            m_last_known;
  bit            m_done, m_pending;
  int            m_clr_n;

  pingpong_clear_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) pif ();

  pingpong_clear_buffer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (D),
    .CLEAR_VALUE (CV),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        vectors++;
        if (pif.read_valid !== mon_e.valid) begin
          miscompares++;
          $display("FAIL sb_read_valid: got %0b want %0b", pif.read_valid, mon_e.valid);
        end
        if (mon_e.chk) begin
          vectors++;
          if (pif.read_data !== mon_e.data) begin
            miscompares++;
            $display("FAIL sb_read_data: got %0h want %0h", pif.read_data, mon_e.data);
          end
        end
      end
    end
  end

  task automatic step(input bit rst, input bit sreq, input bit w, input int wa, input int wd,
                      input int ra);
    sb_t e;
    bit  fire;
    reset          = rst;
    pif.swap_req   = sreq;
    pif.we         = w;
    pif.write_addr = AW'(wa);
    pif.write_data = DW'(wd);
    pif.read_addr  = AW'(ra);
    if (rst) begin
      e.valid = 1'b0; e.data = '0; e.chk = 1'b1;
      m_done = 0; m_pending = 0; m_clr_n = 0;
      foreach (m_known[i]) m_known[i] = 0;
    end else begin
      fire = m_done && (sreq || m_pending);
      if (w) begin
        e.valid = 1'b0; e.data = m_last; e.chk = m_last_known;
      end else if (ra >= int'(D)) begin
        e.valid = 1'b1; e.data = CV; e.chk = 1'b1;
      end else begin
        e.valid = 1'b1; e.data = m_mem[ra]; e.chk = m_known[ra];
      end
      if (w && wa < int'(D)) begin
        m_mem[wa] = DW'(wd);
        m_known[wa] = 1;
      end
      if (fire) begin
        m_done = 0; m_pending = 0; m_clr_n = 0;
        foreach (m_mem[i]) begin
          m_mem[i] = CV;
          m_known[i] = 1;
        end
      end else if (!m_done) begin
        if (sreq) m_pending = 1;
        m_clr_n++;
        if (m_clr_n == int'(D)) m_done = 1;
      end
    end
    m_last = e.data;
    m_last_known = e.chk;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    vectors++; if (pif.active_sel !== 1'b0) begin miscompares++;
      $display("FAIL reset_active_sel: got %0b want 0", pif.active_sel); end
    vectors++; if (pif.swap_count !== 2'd0) begin miscompares++;
      $display("FAIL reset_swap_count: got %0d want 0", pif.swap_count); end
    vectors++; if (pif.swap_ack !== 1'b0) begin miscompares++;
      $display("FAIL reset_swap_ack: got %0b want 0", pif.swap_ack); end
    vectors++; if (pif.clear_done !== 1'b0) begin miscompares++;
      $display("FAIL reset_clear_done: got %0b want 0", pif.clear_done); end
    for (int k = 1; k <= int'(D) + 1; k++) begin
      step(0, 0, 0, 0, 0, 0);
      // After step k the design is in cycle k+1; done shows from cycle D+1.
      vectors++; if (pif.clear_done !== (k >= int'(D))) begin miscompares++;
        $display("FAIL idle_clear_done k=%0d: got %0b want %0b", k, pif.clear_done, k >= int'(D));
      end
    end
    vectors++; if (pif.active_sel !== 1'b0 || pif.swap_count !== 2'd0) begin miscompares++;
      $display("FAIL idle_no_swap: got sel=%0b cnt=%0d want 0/0", pif.active_sel, pif.swap_count);
    end
  endtask

  task automatic test_write_read();
    step(0, 0, 1, 5, 'hA, 0);
    vectors++; if (pif.read_valid !== 1'b0) begin miscompares++;
      $display("FAIL wr_read_valid: got %0b want 0", pif.read_valid); end
    step(0, 0, 1, int'(D) - 1, 'h3, 0);
    step(0, 0, 0, 0, 0, 5);
    vectors++; if (pif.read_valid !== 1'b1 || pif.read_data !== 4'hA) begin miscompares++;
      $display("FAIL rd5: got v=%0b d=%0h want 1/a", pif.read_valid, pif.read_data); end
    step(0, 0, 0, 0, 0, int'(D) - 1);
    vectors++; if (pif.read_valid !== 1'b1 || pif.read_data !== 4'h3) begin miscompares++;
      $display("FAIL rd_last: got v=%0b d=%0h want 1/3", pif.read_valid, pif.read_data); end
  endtask

  task automatic test_swap();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= int'(D) + 2; k++) begin
      step(0, k == 10, k == 20, 5, 'h9, 5);
      vectors++; if (pif.swap_ack !== (k == int'(D) + 1)) begin miscompares++;
        $display("FAIL swap_ack k=%0d: got %0b want %0b", k, pif.swap_ack, k == int'(D) + 1); end
      vectors++; if (pif.active_sel !== (k >= int'(D) + 1)) begin miscompares++;
        $display("FAIL swap_sel k=%0d: got %0b want %0b", k, pif.active_sel, k >= int'(D) + 1);
      end
      if (k == int'(D) + 1) begin
        vectors++; if (pif.read_data !== 4'h9) begin miscompares++;
          $display("FAIL swap_cycle_read: got %0h want 9", pif.read_data); end
      end
    end
    vectors++; if (pif.swap_count !== 2'd1 || pif.clear_done !== 1'b0) begin miscompares++;
      $display("FAIL post_swap: got cnt=%0d done=%0b want 1/0", pif.swap_count, pif.clear_done);
    end
  endtask

  // Continues one clear cycle into the sweep started by test_swap.
  task automatic test_pending_collapse();
    int ra;
    for (int j = 2; j <= int'(D) + 3; j++) begin
      ra = (j == 2) ? 5 : (j == 3) ? int'(D) - 1 : 7;
      step(0, j == 4 || j == 50 || j == 700, j == int'(D) + 1, 7, 'hF, ra);
      if (j == 2 || j == 3) begin
        vectors++; if (pif.read_data !== CV) begin miscompares++;
          $display("FAIL new_buf_clear j=%0d: got %0h want %0h", j, pif.read_data, CV); end
      end
      vectors++; if (pif.swap_ack !== (j == int'(D) + 1)) begin miscompares++;
        $display("FAIL pend_ack j=%0d: got %0b want %0b", j, pif.swap_ack, j == int'(D) + 1); end
    end
    vectors++; if (pif.swap_count !== 2'd2 || pif.active_sel !== 1'b0) begin miscompares++;
      $display("FAIL pend_once: got cnt=%0d sel=%0b want 2/0", pif.swap_count, pif.active_sel);
    end
  endtask

  task automatic test_priority_oob();
    step(0, 0, 0, 0, 0, 7);
    vectors++; if (pif.read_data !== CV) begin miscompares++;
      $display("FAIL swap_write_lost: got %0h want %0h", pif.read_data, CV); end
    step(0, 0, 1, 3, 'hC, 5);
    vectors++; if (pif.read_valid !== 1'b0 || pif.read_data !== CV) begin miscompares++;
      $display("FAIL wr_prio: got v=%0b d=%0h want 0/%0h", pif.read_valid, pif.read_data, CV); end
    step(0, 0, 1, 1030, 'hD, 0);
    step(0, 0, 0, 0, 0, 1030);
    vectors++; if (pif.read_valid !== 1'b1 || pif.read_data !== CV) begin miscompares++;
      $display("FAIL rd_oob: got v=%0b d=%0h want 1/%0h", pif.read_valid, pif.read_data, CV); end
    step(0, 0, 0, 0, 0, 6);
    step(0, 0, 0, 0, 0, 3);
    vectors++; if (pif.read_data !== 4'hC) begin miscompares++;
      $display("FAIL rd_after_prio: got %0h want c", pif.read_data); end
    step(0, 0, 1, int'(D) - 1, 'hE, 0);
    step(0, 0, 0, 0, 0, int'(D) - 1);
    vectors++; if (pif.read_data !== 4'hE) begin miscompares++;
      $display("FAIL rd_last_addr: got %0h want e", pif.read_data); end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4 * (int'(D) + 1); k++) begin
      step(0, 1, 0, 0, 0, k % 17);
      if (k == 3 * (int'(D) + 1)) begin
        vectors++; if (pif.swap_count !== 2'd3) begin miscompares++;
          $display("FAIL level_cnt3: got %0d want 3", pif.swap_count); end
      end
    end
    vectors++; if (pif.swap_count !== 2'd0 || pif.active_sel !== 1'b0) begin miscompares++;
      $display("FAIL cnt_wrap: got cnt=%0d sel=%0b want 0/0", pif.swap_count, pif.active_sel);
    end
  endtask

  task automatic test_reset_midsweep();
    for (int k = 1; k <= int'(D) + 1; k++) step(0, 1, 0, 0, 0, 0);
    vectors++; if (pif.swap_count !== 2'd1 || pif.active_sel !== 1'b1) begin miscompares++;
      $display("FAIL pre_reset: got cnt=%0d sel=%0b want 1/1", pif.swap_count, pif.active_sel);
    end
    for (int k = 1; k <= 500; k++) step(0, k == 100, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    vectors++; if (pif.swap_count !== 2'd0 || pif.active_sel !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset: got cnt=%0d sel=%0b want 0/0", pif.swap_count, pif.active_sel);
    end
    vectors++; if (pif.clear_done !== 1'b0 || pif.read_valid !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset_flags: got done=%0b v=%0b want 0/0", pif.clear_done,
               pif.read_valid); end
    for (int k = 1; k <= int'(D) + 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++; if (pif.clear_done !== (k >= int'(D)) || pif.swap_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL restart k=%0d: got done=%0b ack=%0b want %0b/0", k, pif.clear_done,
                 pif.swap_ack, k >= int'(D)); end
    end
    vectors++; if (pif.swap_count !== 2'd0 || pif.active_sel !== 1'b0) begin miscompares++;
      $display("FAIL pending_dropped: got cnt=%0d sel=%0b want 0/0", pif.swap_count,
               pif.active_sel); end
  endtask

  initial begin
    m_last = '0;
    m_last_known = 1;
    test_reset();
    test_write_read();
    test_swap();
    test_pending_collapse();
    test_priority_oob();
    test_wrap();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
